// File: rtl/axis_nibble_tx.sv
// rtl/axis_nibble_tx.sv - host word to 4-bit stream serializer with one-word holding buffer
// Optional build macro: AXIS_NIBBLE_TX_MSB_FIRST_EN (send the most significant nibble first).
module axis_nibble_tx #(
  parameter int BEATS = 4
) (
  input  logic                 clk_i,
  input  logic                 arstn_i,
  input  logic                 load_valid_i,
  output logic                 load_ready_o,
  input  logic [4*BEATS-1:0]   load_data_i,
  output logic                 tvalid_o,
  input  logic                 tready_i,
  output logic [3:0]           tdata_o,
  output logic                 tlast_o,
  output logic [7:0]           words_o
);

  localparam int W  = 4 * BEATS;
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [W-1:0]  active_q, active_d;
  logic [CW-1:0] beat_q, beat_d;
  logic [W-1:0]  hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic          load_ready_q;
  logic [7:0]    words_q, words_d;

  logic          load_hs;
  logic          beat_hs;
  logic          last_hs;
  logic [W-1:0]  active_shifted;
  logic [3:0]    cur_nibble;

  // Nibble order: the active word is shifted so the next beat always sits at one end.
`ifdef AXIS_NIBBLE_TX_MSB_FIRST_EN
  assign cur_nibble     = active_q[W-1 -: 4];
  assign active_shifted = {active_q[W-5:0], 4'h0};
`else
  assign cur_nibble     = active_q[3:0];
  assign active_shifted = {4'h0, active_q[W-1:4]};
`endif

  assign tvalid_o     = (state_q == S_SEND);
  assign tlast_o      = tvalid_o && (beat_q == LAST_BEAT);
  assign tdata_o      = tvalid_o ? cur_nibble : 4'h0;
  assign load_ready_o = load_ready_q;
  assign words_o      = words_q;

  assign load_hs = load_valid_i && load_ready_q;
  assign beat_hs = tvalid_o && tready_i;
  assign last_hs = beat_hs && (beat_q == LAST_BEAT);

  // Next-state: load into active when idle or on the final beat, otherwise into hold.
  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    beat_d      = beat_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    words_d     = words_q;

    if (state_q == S_IDLE) begin
      if (load_hs) begin
        active_d = load_data_i;
        beat_d   = '0;
        state_d  = S_SEND;
      end
    end else begin
      if (last_hs) begin
        words_d = words_q + 8'd1;
        beat_d  = '0;
        if (hold_full_q) begin
          // Held word follows with no bubble; a simultaneous load refills hold.
          active_d = hold_q;
          if (load_hs) begin
            hold_d = load_data_i;
          end else begin
            hold_full_d = 1'b0;
          end
        end else if (load_hs) begin
          active_d = load_data_i;
        end else begin
          state_d = S_IDLE;
        end
      end else begin
        if (beat_hs) begin
          active_d = active_shifted;
          beat_d   = beat_q + 1'b1;
        end
        if (load_hs) begin
          hold_d      = load_data_i;
          hold_full_d = 1'b1;
        end
      end
    end
  end

  // State registers; reset discards both the active and the held word.
  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      state_q      <= S_IDLE;
      active_q     <= '0;
      beat_q       <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      load_ready_q <= 1'b0;
      words_q      <= 8'd0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      beat_q       <= beat_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      load_ready_q <= !hold_full_d;
      words_q      <= words_d;
    end
  end

endmodule

// File: tb/tb_axis_nibble_tx.sv
// tb/tb_axis_nibble_tx.sv - randomized self-checking bench for axis_nibble_tx
module tb_axis_nibble_tx;

  localparam int BEATS = 4;
  localparam int W     = 4 * BEATS;

  logic         clk = 1'b0;
  logic         arstn;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_data;
  logic         tvalid;
  logic         tready;
  logic [3:0]   tdata;
  logic         tlast;
  logic [7:0]   words;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of pending nibbles, words in flight, sent-word count.
  logic [3:0] exp_nib[$];
  bit         exp_last[$];
  int         inflight = 0;
  logic [7:0] exp_words = 8'd0;
  bit         exp_valid = 1'b0;
  bit         exp_ready = 1'b0;

  axis_nibble_tx #(.BEATS(BEATS)) dut (
    .clk_i        (clk),
    .arstn_i      (arstn),
    .load_valid_i (load_valid),
    .load_ready_o (load_ready),
    .load_data_i  (load_data),
    .tvalid_o     (tvalid),
    .tready_i     (tready),
    .tdata_o      (tdata),
    .tlast_o      (tlast),
    .words_o      (words)
  );

  always #5 clk = ~clk;

  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < BEATS; i++) begin
      int idx;
`ifdef AXIS_NIBBLE_TX_MSB_FIRST_EN
      idx = BEATS - 1 - i;
`else
      idx = i;
`endif
      exp_nib.push_back(w[4*idx +: 4]);
      exp_last.push_back(i == BEATS - 1);
    end
  endtask

  // One clock: decide handshakes from the model's view, clock, then update the model.
  task automatic tick();
    bit lh, bh;
    lh = arstn && load_valid && exp_ready;
    bh = arstn && exp_valid && tready;
    @(posedge clk);
    #1;
    if (!arstn) begin
      exp_nib.delete();
      exp_last.delete();
      inflight  = 0;
      exp_words = 8'd0;
      exp_ready = 1'b0;
    end else begin
      if (bh) begin
        if (exp_last[0]) begin
          inflight--;
          exp_words++;
        end
        void'(exp_nib.pop_front());
        void'(exp_last.pop_front());
      end
      if (lh) begin
        push_word(load_data);
        inflight++;
      end
      exp_ready = (inflight < 2);
    end
    exp_valid = (exp_nib.size() > 0);
  endtask

  task automatic do_reset();
    arstn = 1'b0; load_valid = 1'b0; tready = 1'b0;
    tick();
    arstn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    arstn = 1'b0; load_valid = 1'b1; load_data = W'($urandom); tready = 1'b1;
    repeat (3) tick();
    checks += 5;
    if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b exp 0", tvalid); end
    if (tdata !== 4'h0) begin errors++; $display("FAIL reset_tdata got %h exp 0", tdata); end
    if (tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b exp 0", tlast); end
    if (load_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", load_ready); end
    if (words !== 8'd0) begin errors++; $display("FAIL reset_words got %0d exp 0", words); end
    arstn = 1'b1; load_valid = 1'b0;
    tick();
    checks++;
    if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b exp 1", load_ready); end
  endtask

  task automatic test_single();
    logic [3:0] gold[4];
    logic [3:0] obs[$];
`ifdef AXIS_NIBBLE_TX_MSB_FIRST_EN
    gold = '{4'hA, 4'h5, 4'hC, 4'h3};
`else
    gold = '{4'h3, 4'hC, 4'h5, 4'hA};
`endif
    do_reset();
    tready = 1'b1; load_valid = 1'b1; load_data = 16'hA5C3;
    tick();
    load_valid = 1'b0;
    checks++;
    if (tvalid !== 1'b1) begin errors++; $display("FAIL single_latency tvalid got %b exp 1", tvalid); end
    for (int k = 0; k < 6; k++) begin
      checks += 3;
      if (tvalid !== exp_valid) begin errors++; $display("FAIL single_tvalid got %b exp %b", tvalid, exp_valid); end
      if (load_ready !== exp_ready) begin errors++; $display("FAIL single_ready got %b exp %b", load_ready, exp_ready); end
      if (words !== exp_words) begin errors++; $display("FAIL single_words got %0d exp %0d", words, exp_words); end
      if (exp_valid) begin
        checks += 2;
        if (tdata !== exp_nib[0]) begin errors++; $display("FAIL single_tdata got %h exp %h", tdata, exp_nib[0]); end
        if (tlast !== exp_last[0]) begin errors++; $display("FAIL single_tlast got %b exp %b", tlast, exp_last[0]); end
      end
      if (tvalid) obs.push_back(tdata);
      tick();
    end
    checks += 2;
    if (obs.size() != 4) begin errors++; $display("FAIL single_beat_count got %0d exp 4", obs.size()); end
    else for (int i = 0; i < 4; i++)
      if (obs[i] !== gold[i]) begin errors++; $display("FAIL single_order beat %0d got %h exp %h", i, obs[i], gold[i]); end
    if (words !== 8'd1) begin errors++; $display("FAIL single_words_final got %0d exp 1", words); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] gold[8];
    logic [3:0] obs[$];
    int         cyc[$];
    int         c = 0;
`ifdef AXIS_NIBBLE_TX_MSB_FIRST_EN
    gold = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
`else
    gold = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h8, 4'h7, 4'h6, 4'h5};
`endif
    do_reset();
    tready = 1'b1; load_valid = 1'b1; load_data = 16'h1234;
    tick();
    if (tvalid) begin obs.push_back(tdata); cyc.push_back(c); end
    c++;
    load_data = 16'h5678;
    tick();
    load_valid = 1'b0;
    checks++;
    if (load_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_hold_full got %b exp 0", load_ready); end
    for (int k = 0; k < 10; k++) begin
      checks += 3;
      if (tvalid !== exp_valid) begin errors++; $display("FAIL b2b_tvalid got %b exp %b", tvalid, exp_valid); end
      if (load_ready !== exp_ready) begin errors++; $display("FAIL b2b_ready got %b exp %b", load_ready, exp_ready); end
      if (words !== exp_words) begin errors++; $display("FAIL b2b_words got %0d exp %0d", words, exp_words); end
      if (exp_valid) begin
        checks += 2;
        if (tdata !== exp_nib[0]) begin errors++; $display("FAIL b2b_tdata got %h exp %h", tdata, exp_nib[0]); end
        if (tlast !== exp_last[0]) begin errors++; $display("FAIL b2b_tlast got %b exp %b", tlast, exp_last[0]); end
      end
      if (tvalid) begin obs.push_back(tdata); cyc.push_back(c); end
      c++;
      tick();
    end
    checks += 2;
    if (obs.size() != 8) begin errors++; $display("FAIL b2b_beat_count got %0d exp 8", obs.size()); end
    else begin
      for (int i = 0; i < 8; i++)
        if (obs[i] !== gold[i]) begin errors++; $display("FAIL b2b_order beat %0d got %h exp %h", i, obs[i], gold[i]); end
      if (cyc[7] - cyc[0] != 7) begin errors++; $display("FAIL b2b_gap span got %0d exp 7", cyc[7] - cyc[0]); end
    end
  endtask

  task automatic test_stall();
    logic [3:0] held;
    do_reset();
    tready = 1'b1; load_valid = 1'b1; load_data = W'($urandom);
    tick();
    load_valid = 1'b0;
    tick();
    tready = 1'b0; held = tdata;
    load_valid = 1'b1; load_data = W'($urandom);
    for (int k = 0; k < 10; k++) begin
      tick();
      load_data = W'($urandom);
      checks += 3;
      if (tvalid !== 1'b1) begin errors++; $display("FAIL stall_tvalid got %b exp 1", tvalid); end
      if (tdata !== held) begin errors++; $display("FAIL stall_tdata got %h exp %h", tdata, held); end
      if (load_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %b exp 0", load_ready); end
    end
    tready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      checks += 3;
      if (tvalid !== exp_valid) begin errors++; $display("FAIL stall_drain_tvalid got %b exp %b", tvalid, exp_valid); end
      if (load_ready !== exp_ready) begin errors++; $display("FAIL stall_drain_ready got %b exp %b", load_ready, exp_ready); end
      if (words !== exp_words) begin errors++; $display("FAIL stall_drain_words got %0d exp %0d", words, exp_words); end
      if (exp_valid) begin
        checks += 2;
        if (tdata !== exp_nib[0]) begin errors++; $display("FAIL stall_drain_tdata got %h exp %h", tdata, exp_nib[0]); end
        if (tlast !== exp_last[0]) begin errors++; $display("FAIL stall_drain_tlast got %b exp %b", tlast, exp_last[0]); end
      end
      if (load_valid && exp_ready) begin
        tick();
        load_valid = 1'b0;
      end else begin
        tick();
      end
    end
    checks += 2;
    if (words !== 8'd3) begin errors++; $display("FAIL stall_words_final got %0d exp 3", words); end
    if (tvalid !== 1'b0) begin errors++; $display("FAIL stall_drain_timeout tvalid got %b exp 0", tvalid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tready = 1'b1; load_valid = 1'b1; load_data = W'($urandom);
    tick();
    load_valid = 1'b0;
    tick(); tick();
    arstn = 1'b0;
    tick();
    arstn = 1'b1;
    checks += 2;
    if (tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid got %b exp 0", tvalid); end
    if (words !== 8'd0) begin errors++; $display("FAIL rstmid_words got %0d exp 0", words); end
    tick();
    load_valid = 1'b1; load_data = 16'hFFFF;
    for (int k = 0; k < 8; k++) begin
      if (load_valid && exp_ready) begin
        tick();
        load_valid = 1'b0;
      end else begin
        tick();
      end
      checks += 3;
      if (tvalid !== exp_valid) begin errors++; $display("FAIL rstmid_tvalid_seq got %b exp %b", tvalid, exp_valid); end
      if (load_ready !== exp_ready) begin errors++; $display("FAIL rstmid_ready got %b exp %b", load_ready, exp_ready); end
      if (words !== exp_words) begin errors++; $display("FAIL rstmid_words_seq got %0d exp %0d", words, exp_words); end
      if (exp_valid) begin
        checks += 2;
        if (tdata !== exp_nib[0]) begin errors++; $display("FAIL rstmid_tdata got %h exp %h", tdata, exp_nib[0]); end
        if (tlast !== exp_last[0]) begin errors++; $display("FAIL rstmid_tlast got %b exp %b", tlast, exp_last[0]); end
      end
    end
    checks++;
    if (words !== 8'd1) begin errors++; $display("FAIL rstmid_words_final got %0d exp 1", words); end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 440; k++) begin
      if (k < 400) begin
        tready     = ($urandom_range(0, 9) < 7);
        load_valid = $urandom_range(0, 1);
        load_data  = W'($urandom);
      end else begin
        tready = 1'b1; load_valid = 1'b0;
      end
      tick();
      checks += 3;
      if (tvalid !== exp_valid) begin errors++; $display("FAIL rand_tvalid cyc %0d got %b exp %b", k, tvalid, exp_valid); end
      if (load_ready !== exp_ready) begin errors++; $display("FAIL rand_ready cyc %0d got %b exp %b", k, load_ready, exp_ready); end
      if (words !== exp_words) begin errors++; $display("FAIL rand_words cyc %0d got %0d exp %0d", k, words, exp_words); end
      if (exp_valid) begin
        checks += 2;
        if (tdata !== exp_nib[0]) begin errors++; $display("FAIL rand_tdata cyc %0d got %h exp %h", k, tdata, exp_nib[0]); end
        if (tlast !== exp_last[0]) begin errors++; $display("FAIL rand_tlast cyc %0d got %b exp %b", k, tlast, exp_last[0]); end
      end
    end
    checks++;
    if (tvalid !== 1'b0) begin errors++; $display("FAIL rand_drain_timeout tvalid got %b exp 0", tvalid); end
  endtask

  task automatic test_wrap();
    int loaded = 0;
    do_reset();
    tready = 1'b1;
    for (int k = 0; k < 256 * BEATS + 40; k++) begin
      load_valid = (loaded < 256);
      load_data  = W'($urandom);
      if (load_valid && exp_ready) loaded++;
      tick();
      checks += 3;
      if (tvalid !== exp_valid) begin errors++; $display("FAIL wrap_tvalid cyc %0d got %b exp %b", k, tvalid, exp_valid); end
      if (load_ready !== exp_ready) begin errors++; $display("FAIL wrap_ready cyc %0d got %b exp %b", k, load_ready, exp_ready); end
      if (words !== exp_words) begin errors++; $display("FAIL wrap_words cyc %0d got %0d exp %0d", k, words, exp_words); end
      if (exp_valid) begin
        checks += 2;
        if (tdata !== exp_nib[0]) begin errors++; $display("FAIL wrap_tdata cyc %0d got %h exp %h", k, tdata, exp_nib[0]); end
        if (tlast !== exp_last[0]) begin errors++; $display("FAIL wrap_tlast cyc %0d got %b exp %b", k, tlast, exp_last[0]); end
      end
    end
    load_valid = 1'b0;
    checks += 2;
    if (words !== 8'd0) begin errors++; $display("FAIL wrap_words_final got %0d exp 0", words); end
    if (tvalid !== 1'b0) begin errors++; $display("FAIL wrap_drain_timeout tvalid got %b exp 0", tvalid); end
  endtask

  initial begin
    arstn = 1'b0; load_valid = 1'b0; load_data = '0; tready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_nibble_tx.md
AXIS_NIBBLE_TX -- requirements
Module: axis_nibble_tx

Interface
REQ-001 The block SHALL have parameter BEATS, default 4, giving the number of 4-bit beats per word (legal range 2..8).
REQ-002 The block SHALL have port clk_i, input, 1 bit, the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port arstn_i, input, 1 bit, a synchronous active-low reset sampled on clk_i.
REQ-004 The block SHALL have port load_valid_i, input, 1 bit, host word offered.
REQ-005 The block SHALL have port load_ready_o, output, 1 bit, block can accept a host word.
REQ-006 The block SHALL have port load_data_i, input, 4*BEATS bits, host word.
REQ-007 The block SHALL have port tvalid_o, output, 1 bit, stream beat valid.
REQ-008 The block SHALL have port tready_i, input, 1 bit, downstream ready.
REQ-009 The block SHALL have port tdata_o, output, 4 bits, stream beat data.
REQ-010 The block SHALL have port tlast_o, output, 1 bit, marks the final beat of a word.
REQ-011 The block SHALL have port words_o, output, 8 bits, count of fully sent words.

Function
REQ-012 The block SHALL use a load handshake when load_valid_i && load_ready_o at a rising edge, and a beat handshake when tvalid_o && tready_i at a rising edge.
REQ-013 Storage SHALL be one active shift register plus beat counter and one holding register with a full flag; load_ready_o = !hold_full, registered.
REQ-014 The state machine SHALL have exactly two states: IDLE (active empty, tvalid_o=0) and SEND (active loaded, tvalid_o=1).
REQ-015 In IDLE, an accepted word SHALL go directly into active, moving to SEND with tvalid_o=1 and beat 0 on tdata_o on the next cycle (latency 1).
REQ-016 In SEND, an accepted word SHALL go into the holding register and set hold_full.
REQ-017 Once asserted, tvalid_o, tdata_o and tlast_o SHALL stay stable until the beat handshake.
REQ-018 Each beat handshake SHALL advance the beat counter by one; tlast_o=1 exactly when the counter equals BEATS-1.
REQ-019 On the tlast_o beat handshake with hold_full=1, the held word SHALL move to active with beat 0 next cycle, with no bubble, and hold_full SHALL clear.
REQ-020 On the tlast_o beat handshake with hold_full=0, the block SHALL return to IDLE.
REQ-021 On a last-beat handshake in the same cycle as a load handshake, with hold_full=0, the loaded word SHALL go directly to active (no bubble, no hold use).
REQ-022 On a last-beat handshake in the same cycle as a load handshake, with hold_full=1, the hold moves to active and the loaded word refills hold, so hold_full stays 1; load_ready_o was 0, so this case cannot occur.
REQ-023 words_o SHALL increment by 1 on every tlast_o beat handshake and wrap 255->0.
REQ-024 The block SHALL never lose or duplicate a beat, whatever the tready_i pattern (including held low indefinitely).

Reset
REQ-025 While arstn_i=0 at a rising edge, the block SHALL go to IDLE with tvalid_o=0, tdata_o=0, tlast_o=0, load_ready_o=0, words_o=0, hold_full=0, beat counter 0.
REQ-026 load_ready_o SHALL become 1 on the first edge after arstn_i returns to 1.
REQ-027 Reset mid-word SHALL discard the active and held words; no partial beats are emitted after reset.

Configuration
REQ-028 The block SHALL support macro AXIS_NIBBLE_TX_MSB_FIRST_EN.
REQ-029 With AXIS_NIBBLE_TX_MSB_FIRST_EN defined, beat 0 SHALL carry load_data_i[4*BEATS-1 -: 4] and proceed toward bits [3:0].
REQ-030 Without AXIS_NIBBLE_TX_MSB_FIRST_EN, beat 0 SHALL carry load_data_i[3:0] and proceed toward the MSB nibble; the ports are identical either way.

Verification
REQ-031 Reset then single load 16'hA5C3 with tready_i=1, LSB-first -> tdata_o 3,C,5,A on 4 consecutive cycles starting 1 cycle after load; tlast_o on 4th beat; words_o=1.
REQ-032 Same as REQ-031 with MSB_FIRST_EN defined -> tdata_o A,5,C,3.
REQ-033 Back-to-back loads 16'h1234, 16'h5678 with tready_i=1 -> 8 contiguous beats 4,3,2,1,8,7,6,5 with no gap; load_ready_o low while hold full.
REQ-034 tready_i low for 10 cycles mid-word -> tvalid_o stays 1 and tdata_o stays unchanged; a third load is refused (load_ready_o=0) until the hold drains.
REQ-035 Assert arstn_i=0 for 1 cycle after 2 beats of a word -> tvalid_o=0 next cycle and words_o=0; a new word 16'hFFFF then sends cleanly.
REQ-036 256 words streamed continuously -> words_o wraps to 0.
